reg_shift_sequencer: RTL and testbench

- Multi-cycle controller for the data-processing register-specified shift, the IR[4]==1 operand form that the combinational shifter/sign-extender path does not handle.
- Accepts a start request from the control unit with IR, Rm, Rs and the current C flag.
- Shifts Rm one bit per clock by Rs[7:0] using ARM register-shift semantics, then returns the shifter operand and shifter carry-out with a one-cycle done pulse.
- Sits between the control unit FSM and the ALU operand-B mux.

---
 rtl/arm_shift_pkg.sv | 21 ++
 rtl/reg_shift_sequencer_if.sv | 27 ++
 rtl/shift_step_unit.sv | 39 +++
 rtl/reg_shift_sequencer.sv | 144 ++++++++++++++
 tb/tb_reg_shift_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_shift_pkg.sv
// Shared constants for the ARM register-specified shift sequencer.
// Shift-type and FSM encodings plus the LSL/LSR step cap.
package arm_shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // LSL/LSR by more than 32 needs one extra step to shift a zero into the carry.
    localparam int MAX_LSx_STEPS = 33;

endpackage

// File: rtl/reg_shift_sequencer_if.sv
// Control-unit <-> shift sequencer bundle: request fields in, operand/carry/status out.
// master = control unit side, slave = sequencer side.
interface reg_shift_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [31:0]      ir;
    logic [WIDTH-1:0] rm;
    logic [WIDTH-1:0] rs;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             shift_cout;
    logic             illegal;

    modport master (
        output start, flush, ir, rm, rs, c_in,
        input  busy, done, result, shift_cout, illegal
    );

    modport slave (
        input  start, flush, ir, rm, rs, c_in,
        output busy, done, result, shift_cout, illegal
    );
endinterface

// File: rtl/shift_step_unit.sv
// One-bit ARM shift step (LSL/LSR/ASR/ROR) with carry-out; purely combinational, 0 cycles.
// No flow control: the sequencer decides when a step is committed.
module shift_step_unit
    import arm_shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             carry_in,
    input  shift_t           typ,
    output logic [WIDTH-1:0] value_next,
    output logic             carry_next
);

    always_comb begin
        value_next = value;
        carry_next = carry_in;
        case (typ)
            SH_LSL: begin
                carry_next = value[WIDTH-1];
                value_next = {value[WIDTH-2:0], 1'b0};
            end
            SH_LSR: begin
                carry_next = value[0];
                value_next = {1'b0, value[WIDTH-1:1]};
            end
            SH_ASR: begin
                carry_next = value[0];
                value_next = {value[WIDTH-1], value[WIDTH-1:1]};
            end
            SH_ROR: begin
                carry_next = value[0];
                value_next = {value[0], value[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_shift_sequencer.sv
// Register-specified shift sequencer: one bit per clock, done at start+N+1 (1..34 cycles).
// No backpressure: start is taken only in IDLE, ignored while busy; flush aborts without done.
module reg_shift_sequencer
    import arm_shift_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int AMT_BITS = 8,
    parameter int CNT_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    reg_shift_sequencer_if.slave  bus
);

    localparam int ROT_BITS = $clog2(WIDTH);

    state_t              state;
    shift_t              typ_q;
    logic [WIDTH-1:0]    val_q;
    logic                car_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                illegal_q;
    logic [WIDTH-1:0]    result_q;
    logic                cout_q;

    logic [AMT_BITS-1:0] amt;
    shift_t              typ_in;
    logic                ill;
    logic                ror_wrap;
    logic [CNT_BITS-1:0] n_start;
    logic                car_start;
    logic [WIDTH-1:0]    step_val;
    logic                step_car;
    logic                unused_bits;

    assign unused_bits = ^{bus.ir[31:28], bus.ir[24:7], bus.ir[3:0], bus.rs[WIDTH-1:AMT_BITS]};

    assign amt    = bus.rs[AMT_BITS-1:0];
    assign typ_in = shift_t'(bus.ir[6:5]);
    assign ill    = (bus.ir[27:25] != 3'b000) || !bus.ir[4];

    always_comb begin
        n_start  = '0;
        ror_wrap = 1'b0;
        if (amt != '0) begin
            case (typ_in)
                SH_LSL, SH_LSR:
                    n_start = (amt > AMT_BITS'(MAX_LSx_STEPS)) ? CNT_BITS'(MAX_LSx_STEPS)
                                                              : CNT_BITS'(amt);
                SH_ASR:
                    n_start = (amt > AMT_BITS'(WIDTH)) ? CNT_BITS'(WIDTH) : CNT_BITS'(amt);
                SH_ROR: begin
                    n_start  = CNT_BITS'(amt[ROT_BITS-1:0]);
                    ror_wrap = (amt[ROT_BITS-1:0] == '0);
                end
                default: ;
            endcase
        end
    end

    // A rotate by a non-zero multiple of the width leaves the value alone but reports its MSB as carry.
    assign car_start = (ror_wrap && !ill) ? bus.rm[WIDTH-1] : bus.c_in;

    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .value      (val_q),
        .carry_in   (car_q),
        .typ        (typ_q),
        .value_next (step_val),
        .carry_next (step_car)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            typ_q     <= SH_LSL;
            val_q     <= '0;
            car_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
        end else if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        val_q  <= bus.rm;
                        car_q  <= car_start;
                        typ_q  <= typ_in;
                        busy_q <= 1'b1;
                        if (ill || n_start == '0) begin
                            cnt_q     <= '0;
                            state     <= ST_DONE;
                            done_q    <= 1'b1;
                            illegal_q <= ill;
                            result_q  <= bus.rm;
                            cout_q    <= car_start;
                        end else begin
                            cnt_q <= n_start;
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    val_q <= step_val;
                    car_q <= step_car;
                    cnt_q <= cnt_q - CNT_BITS'(1);
                    if (cnt_q == CNT_BITS'(1)) begin
                        state     <= ST_DONE;
                        done_q    <= 1'b1;
                        illegal_q <= 1'b0;
                        result_q  <= step_val;
                        cout_q    <= step_car;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;
    assign bus.result     = result_q;
    assign bus.shift_cout = cout_q;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Bench for reg_shift_sequencer: arithmetic reference model plus per-cycle output compare.
module tb_reg_shift_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    reg_shift_sequencer_if #(.WIDTH(32)) bus ();

    reg_shift_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    // Expected transaction and the values the outputs must hold outside of it.
    bit          m_active = 1'b0;
    bit          m_has_done = 1'b0;
    int          m_start = 0;
    int          m_end = 0;
    logic [31:0] m_res = '0;
    logic        m_co = 1'b0;
    logic        m_ill = 1'b0;
    logic [31:0] h_res = '0;
    logic        h_co = 1'b0;
    logic        h_ill = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    endfunction

    // Whole-operation ARM register-shift semantics, computed with wide arithmetic.
    function automatic void model(input logic [31:0] ir, input logic [31:0] rm, input logic [31:0] rs,
                                  input logic cin, output logic [31:0] res, output logic co,
                                  output logic ill, output int n);
        logic [63:0]        w;
        logic signed [63:0] s;
        int amt;
        int r;
        amt = int'(rs[7:0]);
        ill = (ir[27:25] != 3'b000) || !ir[4];
        res = rm;
        co  = cin;
        n   = 0;
        if (ill || amt == 0) return;
        case (ir[6:5])
            2'b00: begin
                w   = {32'h0, rm} << amt;
                res = w[31:0];
                co  = w[32];
                n   = (amt > 33) ? 33 : amt;
            end
            2'b01: begin
                w   = {rm, 32'h0} >> amt;
                res = w[63:32];
                co  = w[31];
                n   = (amt > 33) ? 33 : amt;
            end
            2'b10: begin
                n   = (amt > 32) ? 32 : amt;
                s   = {rm, 32'h0};
                s   = s >>> n;
                res = s[63:32];
                co  = s[31];
            end
            default: begin
                r = amt % 32;
                n = r;
                if (r == 0) begin
                    co = rm[31];
                end else begin
                    res = (rm >> r) | (rm << (32 - r));
                    co  = res[31];
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        logic e_busy;
        logic e_done;
        if (cmp_en) begin
            e_busy = m_active && (cyc > m_start) && (cyc <= m_end);
            e_done = m_active && m_has_done && (cyc == m_end);
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("done", 32'(bus.done), 32'(e_done));
            if (e_done) begin
                h_res = m_res;
                h_co  = m_co;
                h_ill = m_ill;
            end
            chk("result", bus.result, h_res);
            chk("shift_cout", 32'(bus.shift_cout), 32'(h_co));
            chk("illegal", 32'(bus.illegal), 32'(h_ill));
            if (m_active && cyc >= m_end) m_active = 1'b0;
        end
    end

    // Issues one start; p_* are hand-computed values that pin the model.
    task automatic run_op(input logic [31:0] ir, input logic [31:0] rm, input logic [31:0] rs,
                          input logic cin, input logic [31:0] p_res, input logic p_co,
                          input logic p_ill, input int p_n);
        logic [31:0] res;
        logic co;
        logic ill;
        int n;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.ir    = ir;
        bus.rm    = rm;
        bus.rs    = rs;
        bus.c_in  = cin;
        model(ir, rm, rs, cin, res, co, ill, n);
        chk("pin_result", res, p_res);
        chk("pin_cout", 32'(co), 32'(p_co));
        chk("pin_illegal", 32'(ill), 32'(p_ill));
        chk("pin_latency", 32'(n), 32'(p_n));
        m_start    = cyc;
        m_end      = cyc + n + 1;
        m_has_done = 1'b1;
        m_res      = res;
        m_co       = co;
        m_ill      = ill;
        m_active   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ir    = 32'hFFFF_FFFF;
        bus.rm    = ~rm;
        bus.rs    = 32'h0000_0005;
        bus.c_in  = ~cin;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 60 && m_active; i++) @(posedge clk);
        @(posedge clk);
        if (m_active) begin
            chk("timeout", 32'(m_active), 32'(0));
            m_active = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.ir     = '0;
        bus.rm     = '0;
        bus.rs     = '0;
        bus.c_in   = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_result", bus.result, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_op(32'h10, 32'h8000_0001, 32'd1,  1'b0, 32'h0000_0002, 1'b1, 1'b0, 1);  wait_end();
        run_op(32'h30, 32'hF000_0000, 32'd40, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 33); wait_end();
        run_op(32'h50, 32'h8000_0000, 32'hFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32); wait_end();
        run_op(32'h70, 32'h0000_0081, 32'd4,  1'b1, 32'h1000_0008, 1'b0, 1'b0, 4);  wait_end();
        run_op(32'h70, 32'h0000_0081, 32'd32, 1'b1, 32'h0000_0081, 1'b0, 1'b0, 0);  wait_end();
        run_op(32'h10, 32'h1234_5678, 32'd0,  1'b1, 32'h1234_5678, 1'b1, 1'b0, 0);  wait_end();
        run_op(32'h00, 32'hCAFE_F00D, 32'd3,  1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 0);  wait_end();
        run_op(32'h0200_0070, 32'h8000_0000, 32'd32, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0); wait_end();
        run_op(32'h10, 32'h0000_0001, 32'd32, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32); wait_end();
        run_op(32'h30, 32'h0000_0003, 32'd1,  1'b0, 32'h0000_0001, 1'b1, 1'b0, 1);  wait_end();
        run_op(32'h50, 32'h4000_0000, 32'd33, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32); wait_end();
        run_op(32'h70, 32'h0000_0001, 32'h121, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1); wait_end();

        // A second start while shifting must be ignored.
        run_op(32'h30, 32'hFFFF_0000, 32'd8, 1'b1, 32'h00FF_FF00, 1'b0, 1'b0, 8);
        bus.start = 1'b1;
        bus.ir    = 32'h10;
        bus.rm    = 32'h0000_0001;
        bus.rs    = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_end();

        // Flush in cycle T+3 of an LSL by 10: idle at T+4, no done, outputs held.
        run_op(32'h10, 32'h0000_0001, 32'd10, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.flush  = 1'b1;
        m_end      = cyc;
        m_has_done = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        wait_end();

        // Flush and start together in idle: start is dropped.
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.ir    = 32'h10;
        bus.rs    = 32'd3;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        // Reset mid-shift clears everything at once, then the block works again.
        run_op(32'h10, 32'h0000_0001, 32'd20, 1'b0, 32'h0010_0000, 1'b0, 1'b0, 20);
        repeat (3) @(posedge clk);
        #1;
        reset_n  = 1'b0;
        m_active = 1'b0;
        h_res    = '0;
        h_co     = 1'b0;
        h_ill    = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_result", bus.result, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_op(32'h10, 32'h0000_0003, 32'd2, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 2); wait_end();

        @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
